// File: rtl/apb_arbiter_2m_if.sv
// One APB bus segment. The "master" modport issues transfers and the "slave" modport completes them.
// Handshake: the master raises psel and holds pwrite/paddr/pwdata stable until the one cycle in which
// pready is high; that cycle completes the transfer and pslverr/prdata are valid only in it.
interface apb_arbiter_2m_if;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic       pready;
  logic       pslverr;
  logic [7:0] prdata;

  modport master (output psel, penable, pwrite, paddr, pwdata, input pready, pslverr, prdata);
  modport slave  (input psel, penable, pwrite, paddr, pwdata, output pready, pslverr, prdata);
endinterface

// File: rtl/apb_arbiter_2m.sv
// Two-master round-robin arbiter in front of a single APB slave, with an ACCESS-phase timeout that
// completes a stuck transfer with an error.
module apb_arbiter_2m #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic             pclk,
  input  logic             preset,
  apb_arbiter_2m_if.slave  m0,
  apb_arbiter_2m_if.slave  m1,
  apb_arbiter_2m_if.master s,
  output logic [1:0]       gnt,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

  state_e     state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic       last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic       done, tmo, pick;
  logic       active, sel1, cpl;
  logic       unused_penable;

  // Master-side penable carries no information the arbiter needs.
  assign unused_penable = m0.penable ^ m1.penable;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    tmo     = 1'b0;
    pick    = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0.psel || m1.psel) begin
          // On a tie the master that did not win last time gets the bus.
          pick    = (m0.psel && m1.psel) ? ~last_q : m1.psel;
          state_d = SETUP;
          gnt_d   = pick ? 2'b10 : 2'b01;
          last_d  = pick;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = 8'd0;
      end
      ACCESS: begin
        if (s.pready) begin
          done = 1'b1;
        end else if ((TIMEOUT_LIM != 8'd0) && (cnt_q == TIMEOUT_LIM)) begin
          tmo = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
        if (done || tmo) begin
          state_d = IDLE;
          gnt_d   = 2'b00;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_comb begin
    active    = (state_q == SETUP) || (state_q == ACCESS);
    sel1      = gnt_q[1];
    // A transfer caught by reset is dropped without a completion strobe.
    cpl       = (done || tmo) && !preset;

    s.psel    = active;
    s.penable = (state_q == ACCESS);
    s.pwrite  = active & (sel1 ? m1.pwrite : m0.pwrite);
    s.paddr   = active ? (sel1 ? m1.paddr : m0.paddr) : 8'h00;
    s.pwdata  = active ? (sel1 ? m1.pwdata : m0.pwdata) : 8'h00;

    m0.pready  = cpl & gnt_q[0];
    m0.pslverr = m0.pready & (tmo | s.pslverr);
    m0.prdata  = (m0.pready && !tmo) ? s.prdata : 8'h00;

    m1.pready  = cpl & gnt_q[1];
    m1.pslverr = m1.pready & (tmo | s.pslverr);
    m1.prdata  = (m1.pready && !tmo) ? s.prdata : 8'h00;
  end

  assign gnt         = gnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/apb_arbiter_2m.md
APB_ARBITER_2M -- requirements
Module: apb_arbiter_2m

Interface
REQ-001 Parameters SHALL be TIMEOUT_CYC, default 16, number of ACCESS cycles without s_pready before forced error completion; 0 disables the timeout; legal range 0..255.
REQ-002 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-003 pclk  in  1  sole clock; all state updates on its rising edge.
REQ-004 preset  in  1  synchronous active-high reset.
REQ-005 mN_psel  in  1  master N (N=0,1) transfer request.
REQ-006 mN_penable  in  1  master N access-phase flag; ignored by arbiter.
REQ-007 mN_pwrite  in  1  master N direction, 1=write.
REQ-008 mN_paddr  in  8  master N address.
REQ-009 mN_pwdata  in  8  master N write data.
REQ-010 mN_pready  out  1  completion strobe to master N.
REQ-011 mN_pslverr  out  1  error to master N, valid only with mN_pready.
REQ-012 mN_prdata  out  8  read data to master N.
REQ-013 s_psel, s_penable, s_pwrite  out  1 each  APB control to the shared slave.
REQ-014 s_paddr, s_pwdata  out  8 each  APB address/write data to the slave.
REQ-015 s_pready, s_pslverr  in  1 each  slave completion/error.
REQ-016 s_prdata  in  8  slave read data.
REQ-017 gnt  out  2  one-hot current owner; 2'b00 when idle.

Function
REQ-018 FSM SHALL have states IDLE, SETUP, ACCESS.
REQ-019 IDLE: if any mN_psel=1 at a clock edge, grant one master and go to SETUP; else stay.
REQ-020 Arbitration: single requester always wins; both requesting -> grant the master not granted last (round-robin pointer last_gnt, updated on each grant).
REQ-021 SETUP: s_psel=1, s_penable=0; next state ACCESS unconditionally (exactly one cycle).
REQ-022 ACCESS: s_psel=1, s_penable=1; stay while s_pready=0 and timeout not reached.
REQ-023 ACCESS with s_pready=1: granted mN_pready=1 in that same cycle (combinational), mN_pslverr=s_pslverr, mN_prdata=s_prdata; next state IDLE.
REQ-024 Minimum transfer = IDLE->SETUP->ACCESS->IDLE; a new grant SHALL NOT occur before one IDLE cycle with s_psel=0.
REQ-025 s_paddr/s_pwrite/s_pwdata SHALL be muxed from the granted master in SETUP/ACCESS and drive 0 in IDLE.
REQ-026 Non-granted master: mN_pready=0, mN_pslverr=0, mN_prdata=0; its request is held pending, never dropped by the arbiter.
REQ-027 Timeout counter (8 bit) SHALL clear on entry to ACCESS and increment each ACCESS cycle with s_pready=0.
REQ-028 When counter equals TIMEOUT_CYC (non-zero) in ACCESS with s_pready=0: granted mN_pready=1, mN_pslverr=1, mN_prdata=0 that cycle; next state IDLE.
REQ-029 s_pready=1 in the timeout cycle SHALL take priority: normal completion, slave's pslverr passed through.
REQ-030 s_pready/s_pslverr/s_prdata SHALL be ignored in IDLE and SETUP.
REQ-031 gnt SHALL be registered, set on the IDLE->SETUP edge, cleared on return to IDLE.

Reset
REQ-032 preset=1 at a clock edge SHALL force IDLE, gnt=0, counter=0, last_gnt=1 (master 0 wins first tie), overriding all other events.
REQ-033 Reset values: all s_* outputs 0, all mN_pready/mN_pslverr/mN_prdata 0.
REQ-034 Reset during SETUP/ACCESS SHALL abort the transfer silently: no mN_pready pulse.

Verification
REQ-035 m0 write addr 8'h10 data 8'hA5, slave pready=1 immediately -> s_psel 2 cycles, s_penable 1 cycle, s_paddr=10, s_pwdata=A5, m0_pready one cycle, gnt=01.
REQ-036 m0 and m1 request same cycle after reset, repeated 3 times -> grant order m0,m1,m0; each separated by one IDLE cycle.
REQ-037 m1 read addr 8'h3C, slave pready after 3 wait cycles with prdata 8'h5A -> m1_prdata=5A with m1_pready, ACCESS lasts 4 cycles, m0 outputs stay 0.
REQ-038 Slave never asserts pready, TIMEOUT_CYC=16 -> m0_pready=1 and m0_pslverr=1 in 17th ACCESS cycle, s_psel=0 next cycle.
REQ-039 Slave pready=1 with pslverr=1 on exactly the timeout cycle -> normal completion, mN_pslverr=1 from slave, prdata passed through.
REQ-040 preset asserted in ACCESS of m1 transfer -> next cycle IDLE, all outputs 0, no m1_pready; subsequent tie grants m0.
